or4_share_arbiter: RTL and testbench

OR4_SHARE_ARBITER -- requirements
Module: or4_share_arbiter

---
 rtl/or4_share_arbiter.sv | 119 +++++++++++
 tb/tb_or4_share_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/or4_share_arbiter.sv
// Four requesters share one external 74x32 quad OR gate: round-robin grant, hold the
// operands for SETTLE_CYCLES, sample OR_Y once, then return the result with a valid/ready handshake.
module or4_share_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  REQ_VALID,
  input  logic [15:0] REQ_A,
  input  logic [15:0] REQ_B,
  output logic [3:0]  REQ_READY,
  output logic [3:0]  RSP_VALID,
  output logic [3:0]  RSP_Y,
  input  logic [3:0]  RSP_READY,
  output logic [3:0]  OR_A,
  output logic [3:0]  OR_B,
  input  logic [3:0]  OR_Y,
  output logic        BUSY,
  output logic [1:0]  GRANT_ID,
  output logic [1:0]  DBG_STATE
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // REQ_READY is combinational from REQ_VALID in IDLE; RSP_VALID is held until RSP_READY[grant].

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [1:0]  r_last;
  logic [1:0]  r_grant;
  logic [3:0]  r_or_a;
  logic [3:0]  r_or_b;
  logic [3:0]  r_rsp_y;
  logic [1:0]  w_grant;
  logic        w_found;
  logic        w_accept;
  logic        w_capture;
  logic        w_done;

  // Search starts one past the last completed grant so every requester gets a turn.
  always_comb begin
    w_grant = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && REQ_VALID[2'(r_last + 2'(k))]) begin
        w_grant = 2'(r_last + 2'(k));
        w_found = 1'b1;
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_found;
  assign w_capture = (r_state == S_SETTLE) && (r_cnt == 4'd1);
  assign w_done    = (r_state == S_RESPOND) && RSP_READY[r_grant];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept)  w_next = S_SETTLE;
      S_SETTLE:  if (w_capture) w_next = S_RESPOND;
      S_RESPOND: if (w_done)    w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    REQ_READY = 4'b0000;
    RSP_VALID = 4'b0000;
    if (w_accept && RST_N) REQ_READY = 4'b0001 << w_grant;
    if (r_state == S_RESPOND) RSP_VALID = 4'b0001 << r_grant;
    BUSY      = (r_state != S_IDLE);
    DBG_STATE = r_state;
  end

  // Operands stay on the gate after completion; only the next accept replaces them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt   <= 4'd0;
      r_last  <= 2'd3;
      r_grant <= 2'd0;
      r_or_a  <= 4'd0;
      r_or_b  <= 4'd0;
      r_rsp_y <= 4'd0;
    end else begin
      if (w_accept) begin
        r_or_a  <= REQ_A[{w_grant, 2'b00} +: 4];
        r_or_b  <= REQ_B[{w_grant, 2'b00} +: 4];
        r_grant <= w_grant;
        r_cnt   <= LP_SETTLE;
      end else if (r_state == S_SETTLE) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) r_rsp_y <= OR_Y;
      if (w_done)    r_last  <= r_grant;
    end
  end

  assign OR_A     = r_or_a;
  assign OR_B     = r_or_b;
  assign RSP_Y    = r_rsp_y;
  assign GRANT_ID = r_grant;

endmodule

// File: tb/tb_or4_share_arbiter.sv
// Bench for or4_share_arbiter: a SETTLE_CYCLES=2 instance with an ideal OR gate model and
// a SETTLE_CYCLES=3 instance whose OR_Y is driven directly to probe the single-sample rule.
module tb_or4_share_arbiter;

  localparam int S = 2;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  REQ_VALID;
  logic [15:0] REQ_A;
  logic [15:0] REQ_B;
  logic [3:0]  REQ_READY;
  logic [3:0]  RSP_VALID;
  logic [3:0]  RSP_Y;
  logic [3:0]  RSP_READY;
  logic [3:0]  OR_A;
  logic [3:0]  OR_B;
  logic [3:0]  OR_Y;
  logic        BUSY;
  logic [1:0]  GRANT_ID;
  logic [1:0]  DBG_STATE;

  logic [3:0]  d3_req_valid;
  logic [15:0] d3_req_a;
  logic [15:0] d3_req_b;
  logic [3:0]  d3_req_ready;
  logic [3:0]  d3_rsp_valid;
  logic [3:0]  d3_rsp_y;
  logic [3:0]  d3_rsp_ready;
  logic [3:0]  d3_or_a;
  logic [3:0]  d3_or_b;
  logic [3:0]  d3_or_y;
  logic        d3_busy;
  logic [1:0]  d3_grant_id;
  logic [1:0]  d3_dbg_state;

  int          n_total;
  int          n_pass;
  logic [1:0]  m_last;
  logic [3:0]  m_y;

  assign OR_Y = OR_A | OR_B;

  or4_share_arbiter #(.SETTLE_CYCLES(S)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_Y(RSP_Y), .RSP_READY(RSP_READY),
    .OR_A(OR_A), .OR_B(OR_B), .OR_Y(OR_Y), .BUSY(BUSY), .GRANT_ID(GRANT_ID),
    .DBG_STATE(DBG_STATE)
  );

  or4_share_arbiter #(.SETTLE_CYCLES(3)) u_dut3 (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(d3_req_valid), .REQ_A(d3_req_a), .REQ_B(d3_req_b),
    .REQ_READY(d3_req_ready), .RSP_VALID(d3_rsp_valid), .RSP_Y(d3_rsp_y),
    .RSP_READY(d3_rsp_ready), .OR_A(d3_or_a), .OR_B(d3_or_b), .OR_Y(d3_or_y),
    .BUSY(d3_busy), .GRANT_ID(d3_grant_id), .DBG_STATE(d3_dbg_state)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference arbitration: first valid requester after the last completed one, with wrap.
  function automatic logic [1:0] model_pick(input logic [3:0] mask, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
    end
    return last;
  endfunction

  // One complete operation; returns one cycle after the handshake edge was armed.
  task automatic do_op(input logic [3:0] mask, input int delay, input bit others_hi);
    logic [1:0] g;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [3:0] oh;
    logic [3:0] rr;
    @(negedge CLK);
    REQ_VALID = mask;
    REQ_A     = 16'($urandom);
    REQ_B     = 16'($urandom);
    RSP_READY = 4'($urandom);
    g  = model_pick(mask, m_last);
    ea = REQ_A[int'(g) * 4 +: 4];
    eb = REQ_B[int'(g) * 4 +: 4];
    oh = 4'b0001 << g;
    #1;
    chk("idle_busy", 16'(BUSY), 16'd0);
    chk("idle_rsp_valid", 16'(RSP_VALID), 16'd0);
    chk("idle_rsp_y_hold", 16'(RSP_Y), 16'(m_y));
    chk("accept_req_ready", 16'(REQ_READY), 16'(oh));
    for (int i = 0; i < S; i++) begin
      @(negedge CLK);
      REQ_VALID = 4'($urandom);
      REQ_A     = 16'($urandom);
      REQ_B     = 16'($urandom);
      #1;
      chk("settle_req_ready", 16'(REQ_READY), 16'd0);
      chk("settle_rsp_valid", 16'(RSP_VALID), 16'd0);
      chk("settle_busy", 16'(BUSY), 16'd1);
      chk("or_a", 16'(OR_A), 16'(ea));
      chk("or_b", 16'(OR_B), 16'(eb));
      chk("grant_id", 16'(GRANT_ID), 16'(g));
    end
    for (int i = 0; i <= delay; i++) begin
      @(negedge CLK);
      REQ_VALID = 4'($urandom);
      rr = others_hi ? ~oh : (4'($urandom) & ~oh);
      if (i == delay) rr = rr | oh;
      RSP_READY = rr;
      #1;
      chk("rsp_valid", 16'(RSP_VALID), 16'(oh));
      chk("rsp_y", 16'(RSP_Y), 16'(ea | eb));
      chk("respond_req_ready", 16'(REQ_READY), 16'd0);
      chk("respond_busy", 16'(BUSY), 16'd1);
    end
    m_last = g;
    m_y    = ea | eb;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    m_last  = 2'd3;
    m_y     = 4'd0;
    RST_N = 1'b0;
    REQ_VALID = '0; REQ_A = '0; REQ_B = '0; RSP_READY = '0;
    d3_req_valid = '0; d3_req_a = '0; d3_req_b = '0; d3_rsp_ready = '0; d3_or_y = '0;

    #7;
    chk("rst_req_ready", 16'(REQ_READY), 16'd0);
    chk("rst_rsp_valid", 16'(RSP_VALID), 16'd0);
    chk("rst_rsp_y", 16'(RSP_Y), 16'd0);
    chk("rst_or_a", 16'(OR_A), 16'd0);
    chk("rst_or_b", 16'(OR_B), 16'd0);
    chk("rst_grant_id", 16'(GRANT_ID), 16'd0);
    chk("rst_busy", 16'(BUSY), 16'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Full rotation with every requester asking and responses taken immediately.
    for (int i = 0; i < 5; i++) do_op(4'hF, 0, 1'b1);
    // Requester 1 stalls its response, first with random then with all other ready bits high.
    do_op(4'b0010, 5, 1'b0);
    do_op(4'b0010, 3, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      do_op(mask, int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Abort requester 2 mid-settle with an asynchronous reset.
    @(negedge CLK);
    REQ_VALID = 4'b0100;
    RSP_READY = 4'b0000;
    REQ_A = 16'($urandom);
    REQ_B = 16'($urandom);
    #1;
    chk("idle_before_abort_busy", 16'(BUSY), 16'd0);
    chk("abort_accept", 16'(REQ_READY), 16'(4'b0001 << model_pick(4'b0100, m_last)));
    @(negedge CLK);
    REQ_VALID = 4'b0101;
    #1;
    chk("abort_settle_busy", 16'(BUSY), 16'd1);
    chk("abort_grant", 16'(GRANT_ID), 16'd2);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_req_ready", 16'(REQ_READY), 16'd0);
    chk("async_rsp_valid", 16'(RSP_VALID), 16'd0);
    chk("async_rsp_y", 16'(RSP_Y), 16'd0);
    chk("async_or_a", 16'(OR_A), 16'd0);
    chk("async_or_b", 16'(OR_B), 16'd0);
    chk("async_grant_id", 16'(GRANT_ID), 16'd0);
    chk("async_busy", 16'(BUSY), 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      chk("in_reset_rsp_valid", 16'(RSP_VALID), 16'd0);
      chk("in_reset_req_ready", 16'(REQ_READY), 16'd0);
    end
    @(negedge CLK);
    RST_N  = 1'b1;
    m_last = 2'd3;
    m_y    = 4'd0;
    #1;
    chk("post_reset_priority", 16'(REQ_READY), 16'(4'b0001 << model_pick(4'b0101, m_last)));
    REQ_VALID = 4'b0000;
    #1;
    chk("post_reset_rsp_valid", 16'(RSP_VALID), 16'd0);
    do_op(4'b0101, 1, 1'b0);
    do_op(4'b0101, 0, 1'b0);
    @(negedge CLK);
    REQ_VALID = 4'b0000;
    #1;
    chk("final_idle_busy", 16'(BUSY), 16'd0);
    chk("final_rsp_y_hold", 16'(RSP_Y), 16'(m_y));

    // OR_Y must be sampled only on the capture edge, three edges after accept.
    @(negedge CLK);
    d3_req_valid = 4'b0001;
    d3_req_a = 16'h0001;
    d3_req_b = 16'h0002;
    d3_or_y  = 4'h0;
    #1;
    chk("d3_req_ready", 16'(d3_req_ready), 16'h1);
    @(negedge CLK);
    d3_req_valid = 4'b0000;
    d3_or_y = 4'h3;
    #1;
    chk("d3_or_a", 16'(d3_or_a), 16'h1);
    chk("d3_or_b", 16'(d3_or_b), 16'h2);
    @(negedge CLK);
    d3_or_y = 4'h0;
    #1;
    chk("d3_settle2_rsp_valid", 16'(d3_rsp_valid), 16'h0);
    @(negedge CLK);
    d3_or_y = 4'hC;
    #1;
    chk("d3_settle3_rsp_valid", 16'(d3_rsp_valid), 16'h0);
    @(negedge CLK);
    d3_or_y = 4'h5;
    #1;
    chk("d3_rsp_valid", 16'(d3_rsp_valid), 16'h1);
    chk("d3_rsp_y", 16'(d3_rsp_y), 16'hC);
    @(negedge CLK);
    d3_rsp_ready = 4'b0001;
    #1;
    chk("d3_rsp_y_ignores_late_or_y", 16'(d3_rsp_y), 16'hC);
    @(negedge CLK);
    d3_rsp_ready = 4'b0000;
    #1;
    chk("d3_done_rsp_valid", 16'(d3_rsp_valid), 16'h0);
    chk("d3_done_busy", 16'(d3_busy), 16'h0);
    chk("d3_done_rsp_y_hold", 16'(d3_rsp_y), 16'hC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
